quadratic_map_descrambler: RTL
==============================

// Module: quadratic_map_descrambler
// PURPOSE
// - Receive-side end of the chaotic stream cipher: regenerates the quadratic-map keystream from a shared
//   seed/r pair and XORs it onto incoming ciphertext words to recover plaintext.
// - Sits between the link receiver (ciphertext, valid/ready) and the payload sink. Mirrors the transmit-side
//   map generator bit-exactly, so both ends produce identical x_n sequences.
// PARAMETERS
// - WIDTH   16  data/keystream word width; the map state is fixed Q1.15, so only 16 is supported
// - WARMUP  64  map iterations discarded after cfg_load before the first keystream word (0 = none)
// PORTS
// - clk       in   1   clock
// - reset     in   1   synchronous, active-high reset
// - cfg_load  in   1   1-cycle pulse: latch cfg_seed/cfg_r and restart the sequence
// - cfg_seed  in   16  x_0, signed Q1.15
// - cfg_r     in   16  map parameter r, signed Q2.14
// - s_data    in   16  ciphertext word
// - s_valid   in   1   ciphertext valid
// - s_ready   out  1   ciphertext accept
// - m_data    out  16  plaintext word = s_data ^ keystream
// - m_valid   out  1   plaintext valid
// - m_ready   in   1   sink accept
// - locked    out  1   high in RUN (warm-up done)
// BEHAVIOUR
// - Reset values: s_ready=0, m_valid=0, m_data=0, locked=0; state IDLE; x, r, ks and counters cleared.
// - Map: x_{n+1} = sat16(0x4000 - ((r * sq) >>> 14)), sq = (x_n*x_n) >>> 15 kept 17 bits unsigned (x=-1 gives 0x8000).
//   Product r*sq is 33-bit signed, arithmetic shift; sat16 clamps to [0x8000, 0x7FFF]. One iteration = 2 cycles
//   (stage 1: square; stage 2: scale, subtract, saturate, write x).
// - Keystream word k_i = x_{WARMUP+i}, i>=1; with WARMUP=0, k_1 = f(seed).
// - FSM: IDLE -> (cfg_load) WARM: run WARMUP back-to-back iterations, count 0..WARMUP-1, results only update x;
//   WARM -> RUN after the last one (WARMUP=0: directly to RUN). RUN: launch one iteration, result -> ks,
//   ks_valid=1; the next iteration launches when ks is consumed.
// - s_ready = RUN & ks_valid & (!m_valid | m_ready). Transfer on s_valid & s_ready at cycle T:
//   m_data <= s_data ^ ks, m_valid <= 1 at T+1; ks_valid clears; next ks valid at T+2. Peak rate 1 word / 2 cycles.
// - m_valid holds and m_data stays stable until m_ready; m_valid & m_ready with no new transfer clears m_valid.
// - cfg_load in any state (incl. mid-warm-up/mid-iteration): abort the in-flight iteration, drop ks and any pending
//   m_valid word, x <= cfg_seed, r <= cfg_r, enter WARM (or RUN); locked=0 until RUN. cfg_load wins over
//   a same-cycle s transfer (s_ready is low that cycle).
// - reset mid-operation: identical to the reset values above; no residual output.
// STRUCTURE
// - Package chaos_pkg: Q-format constants (HALF=16'h4000, Q1.15/Q2.14 shift amounts), state enum
//   {IDLE, WARM, RUN}, sat16 function, shared with the transmit-side generator.
// - Sub-module quadratic_map_iter: 2-stage iteration datapath (start, x_in, r_in -> done, x_out); the top holds FSM,
//   warm-up counter, ks register and output skid logic.
// TESTING
// - WARMUP=0, seed 0x0000, r 0x4000; send 0x1234, 0xFFFF, 0x0000 -> m_data 0x5234, 0xDFFF, 0x3800 (k=0x4000,0x2000,0x3800).
// - Saturation: seed 0x8000, r 0x8000, WARMUP=0; send 0x0000 -> m_data 0x7FFF.
// - WARMUP=64: after cfg_load, s_ready and locked stay 0 for exactly 128 cycles, then locked=1; output matches
//   a software model of k_1 = x_65.
// - Backpressure: m_ready=0 for 10 cycles with s_valid=1 -> one word accepted, m_data stable, s_ready=0; release
//   -> stream resumes with no loss/duplication; sustained throughput 1 word/2 cycles.
// - cfg_load mid-warm-up and with m_valid pending -> m_valid drops next cycle, sequence restarts from new seed.
// - reset asserted during RUN with data in flight -> all outputs 0 next cycle; after new cfg_load, k_1 matches model.

Source files
------------

// File: rtl/quadratic_map_descrambler_pkg.sv
// Shared Q-format constants, FSM states and the saturation helper used by the
// quadratic-map keystream generators on both ends of the link.
package chaos_pkg;

  localparam logic signed [15:0] HALF      = 16'sh4000;
  localparam int                 Q15_SHIFT = 15;
  localparam int                 Q14_SHIFT = 14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WARM = 2'd1,
    RUN  = 2'd2
  } state_e;

  function automatic logic signed [15:0] sat16(input logic signed [33:0] v);
    if (v > 34'sd32767) begin
      return 16'sh7fff;
    end else if (v < -34'sd32768) begin
      return 16'sh8000;
    end else begin
      return v[15:0];
    end
  endfunction

endpackage

// File: rtl/quadratic_map_descrambler_iter.sv
// Two-stage quadratic-map iteration: stage 1 squares x (Q1.15), stage 2 scales by r,
// subtracts from one half and saturates. done/x_out are valid in the stage-2 cycle.
module quadratic_map_iter
  import chaos_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               abort,
  input  logic               start,
  input  logic signed [15:0] x_in,
  input  logic signed [15:0] r_in,
  output logic               done,
  output logic signed [15:0] x_out
);

  logic signed [31:0] x_sq;
  logic        [16:0] sq_d;
  logic        [16:0] sq_q;
  logic               busy_d;
  logic               busy_q;
  logic signed [33:0] prod;
  logic signed [33:0] diff;

  // Square is non-negative, so 17 unsigned bits hold it (x = -1 gives 0x8000).
  always_comb begin
    x_sq   = 32'(x_in) * 32'(x_in);
    sq_d   = start ? 17'(x_sq >>> Q15_SHIFT) : sq_q;
    busy_d = start & ~abort;
  end

  always_comb begin
    prod  = 34'(r_in) * $signed({17'b0, sq_q});
    diff  = 34'(HALF) - (prod >>> Q14_SHIFT);
    x_out = sat16(diff);
    done  = busy_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sq_q   <= '0;
      busy_q <= 1'b0;
    end else begin
      sq_q   <= sq_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/quadratic_map_descrambler.sv
// Receive-side chaotic stream descrambler: regenerates the quadratic-map keystream
// from the shared seed/r pair and XORs it onto ciphertext. Only WIDTH=16 is meaningful.
module quadratic_map_descrambler
  import chaos_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int WARMUP = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_load,
  input  logic [WIDTH-1:0] cfg_seed,
  input  logic [WIDTH-1:0] cfg_r,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             locked
);

  state_e                  state_q;
  state_e                  state_d;
  logic signed [WIDTH-1:0] x_q;
  logic signed [WIDTH-1:0] x_d;
  logic signed [WIDTH-1:0] r_q;
  logic signed [WIDTH-1:0] r_d;
  logic        [WIDTH-1:0] ks_q;
  logic        [WIDTH-1:0] ks_d;
  logic                    ks_valid_q;
  logic                    ks_valid_d;
  logic        [15:0]      warm_cnt_q;
  logic        [15:0]      warm_cnt_d;
  logic        [WIDTH-1:0] m_data_q;
  logic        [WIDTH-1:0] m_data_d;
  logic                    m_valid_q;
  logic                    m_valid_d;

  logic                    xfer;
  logic                    warm_last;
  logic                    iter_start;
  logic                    iter_done;
  logic signed [WIDTH-1:0] iter_x;

  quadratic_map_iter u_iter (
    .clk   (clk),
    .reset (reset),
    .abort (cfg_load),
    .start (iter_start),
    .x_in  (x_q),
    .r_in  (r_q),
    .done  (iter_done),
    .x_out (iter_x)
  );

  assign warm_last = (warm_cnt_q == 16'(WARMUP - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (cfg_load) begin
      state_d = (WARMUP == 0) ? RUN : WARM;
    end else if ((state_q == WARM) && iter_done && warm_last) begin
      state_d = RUN;
    end
  end

  // The next RUN iteration launches in the same cycle ks is consumed, which is
  // what sustains one word every two cycles.
  always_comb begin
    locked     = (state_q == RUN);
    s_ready    = locked & ks_valid_q & (~m_valid_q | m_ready) & ~cfg_load;
    xfer       = s_valid & s_ready;
    iter_start = 1'b0;
    if (!cfg_load && !iter_done) begin
      if (state_q == WARM) begin
        iter_start = 1'b1;
      end else if (state_q == RUN) begin
        iter_start = ~ks_valid_q | xfer;
      end
    end
  end

  always_comb begin
    x_d        = x_q;
    r_d        = r_q;
    ks_d       = ks_q;
    ks_valid_d = ks_valid_q;
    warm_cnt_d = warm_cnt_q;
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    if (cfg_load) begin
      x_d        = cfg_seed;
      r_d        = cfg_r;
      ks_d       = '0;
      ks_valid_d = 1'b0;
      warm_cnt_d = '0;
      m_data_d   = '0;
      m_valid_d  = 1'b0;
    end else begin
      if (iter_done) begin
        x_d = iter_x;
        if (state_q == WARM) begin
          warm_cnt_d = warm_cnt_q + 16'd1;
        end
        if (state_q == RUN) begin
          ks_d       = iter_x;
          ks_valid_d = 1'b1;
        end
      end else if (xfer) begin
        ks_valid_d = 1'b0;
      end
      if (xfer) begin
        m_data_d  = s_data ^ ks_q;
        m_valid_d = 1'b1;
      end else if (m_ready) begin
        m_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q        <= '0;
      r_q        <= '0;
      ks_q       <= '0;
      ks_valid_q <= 1'b0;
      warm_cnt_q <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
    end else begin
      x_q        <= x_d;
      r_q        <= r_d;
      ks_q       <= ks_d;
      ks_valid_q <= ks_valid_d;
      warm_cnt_q <= warm_cnt_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
    end
  end

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;

endmodule
